scope_capture: RTL
==================

Name: scope_capture

Overview:
- Triggered two-channel capture buffer that sits directly downstream of the sine generator.
- Consumes its two 8-bit sample streams (in-phase and offset-phase), waits for a rising-edge trigger on channel 1, then records DEPTH consecutive sample pairs into internal RAM.
- Afterwards it streams the recorded pairs out over a valid/ready interface to the display/logging stage.
- Acts as a single-shot oscilloscope front end for the sine datapath.

Parameters:
DATA_WIDTH  8  width of each sample channel
ADDR_WIDTH  8  capture RAM address width; DEPTH = 2**ADDR_WIDTH pairs (256)

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  sample strobe, same enable that advances the generator; din1/din2 sampled only when en=1
din1  input  DATA_WIDTH  channel-1 sample (trigger source)
din2  input  DATA_WIDTH  channel-2 sample
trig_level  input  DATA_WIDTH  unsigned trigger threshold
arm  input  1  single-cycle request to start a capture
busy  output  1  high in ARMED, CAPTURE, READOUT
done  output  1  one-cycle pulse after the last readout beat is accepted
rd_valid  output  1  readout data valid
rd_ready  input  1  downstream accepts the beat when rd_valid&&rd_ready
rd_data1  output  DATA_WIDTH  stored channel-1 sample
rd_data2  output  DATA_WIDTH  stored channel-2 sample
rd_last  output  1  high with the final beat (index DEPTH-1)

Behaviour:
- Reset: state=IDLE; busy, done, rd_valid and rd_last all 0; rd_data1/rd_data2 = 0; write/read pointers = 0.
- Reset does not clear RAM contents. Reset in any state aborts the capture or readout immediately.
- FSM states: IDLE, ARMED, CAPTURE, READOUT.
- IDLE:
  - arm=1 -> ARMED next cycle; prev_valid cleared.
  - Any en in the same cycle as arm is ignored.
- ARMED:
  - On each en: prev <= din1, prev_valid <= 1.
  - Trigger = en && prev_valid && (prev < trig_level) && (din1 >= trig_level), unsigned compare.
  - The first en after arming can never trigger.
  - On trigger: write {din1,din2} to RAM[0], wr_ptr <= 1, go to CAPTURE.
- CAPTURE:
  - On each en: write pair at RAM[wr_ptr], wr_ptr++.
  - The write at wr_ptr=DEPTH-1 moves to READOUT on the next cycle; no pointer wrap is used.
  - Cycles with en=0 write nothing.
- READOUT:
  - RAM read is synchronous (1-cycle latency); a prefetch register hides it.
  - rd_valid rises no later than 2 cycles after entering READOUT.
  - Beats are delivered in write order, index 0..DEPTH-1.
  - While rd_valid=1 and rd_ready=0: rd_data1/2 and rd_last are held stable and rd_valid stays 1.
  - Full throughput: with rd_ready held high, one beat per cycle after the first.
  - On acceptance of the beat with rd_last=1: rd_valid <= 0, done <= 1 for one cycle, return to IDLE.
- arm is ignored in every state except IDLE.
- en/din are ignored in IDLE and READOUT; samples arriving during READOUT are dropped.
- Never triggers if din1 never crosses trig_level; ARMED persists until rst.
- trig_level=0: prev<0 is impossible, so the block never triggers (documented, not an error).
- Pointers are ADDR_WIDTH+1 bits internally so the full/last condition is unambiguous.

Decomposition:
- Package scope_pkg: state enum (IDLE, ARMED, CAPTURE, READOUT) and DATA_WIDTH/ADDR_WIDTH defaults.
- One natural sub-module: capture_ram.
  - Simple dual-port: one write port, one synchronous read port.
  - Width 2*DATA_WIDTH, depth 2**ADDR_WIDTH.
  - Kept separate so it can map to block RAM.
- FSM, trigger detect and readout skid/prefetch logic live in the top module.

Test Plan:
- Reset mid-capture: rst asserted after 10 CAPTURE writes -> next cycle busy=0, rd_valid=0, state IDLE; re-arm captures from index 0.
- Basic capture: trig_level=128, din1 ramp 0,1,2,... on every en, din2=din1+64, arm pulsed.
  - Expect trigger at din1=128.
  - 256 beats read with rd_ready=1: rd_data1 = 128..255,0..127 (8-bit wrap), rd_data2 = rd_data1+64 mod 256.
  - rd_last only on beat 255; one done pulse.
- Trigger qualification: din1 sequence 200,200,50,127,128 after arm with trig_level=128 -> no trigger on 200 (no prior sample, not rising); trigger on 128 (prev 127); RAM[0].ch1=128.
- Backpressure: toggle rd_ready pseudo-randomly -> every beat appears exactly once, in order, with data stable while rd_valid&&!rd_ready; total 256 beats.
- Gapped enable: en high 1 cycle in 3 during CAPTURE -> exactly 256 pairs stored, matching only the en-qualified samples.
- Ignored inputs: arm pulsed during CAPTURE and READOUT, en/din changing during READOUT -> no restart, readout data unchanged; trig_level=0 with arm -> busy stays 1, no trigger after 1000 samples.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and default sizes for the triggered two-channel scope capture block.
package scope_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_READOUT
  } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample-pair store: one write port, one synchronous read port.
module capture_ram #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [WIDTH-1:0]      rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset on purpose; a reset port would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register only moves on rd_en_i, so an unconsumed word stays put.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/scope_capture.sv
// Single-shot two-channel capture: arm, wait for a rising crossing on din1, record
// DEPTH pairs, then stream them out over valid/ready with a one-word prefetch.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic [DATA_WIDTH-1:0] din2,
  input  logic [DATA_WIDTH-1:0] trig_level,
  input  logic                  arm,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  rd_last
);

  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  pend_q, pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic                  done_q, done_d;

  logic                  trigger;
  logic                  load_out;
  logic                  accept;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [PAIR_W-1:0]     ram_rdata;

  capture_ram #(
    .WIDTH      (PAIR_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i ({din1, din2}),
    .rd_en_i   (ram_re),
    .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data_o (ram_rdata)
  );

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pend_d       = pend_q;
    rd_valid_d   = rd_valid_q;
    rd_last_d    = rd_last_q;
    rd_data1_d   = rd_data1_q;
    rd_data2_d   = rd_data2_q;
    done_d       = 1'b0;
    trigger      = 1'b0;
    load_out     = 1'b0;
    accept       = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = wr_ptr_q[ADDR_WIDTH-1:0];

    unique case (state_q)
      ST_IDLE: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        pend_d   = 1'b0;
        if (arm) begin
          state_d      = ST_ARMED;
          prev_valid_d = 1'b0;
        end
      end

      ST_ARMED: begin
        // Rising crossing only: the previous accepted sample must sit strictly below the level.
        trigger = en && prev_valid_q && (prev_q < trig_level) && (din1 >= trig_level);
        if (en) begin
          prev_d       = din1;
          prev_valid_d = 1'b1;
        end
        if (trigger) begin
          ram_we    = 1'b1;
          ram_waddr = '0;
          wr_ptr_d  = ONE_PTR;
          state_d   = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (en) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_PTR;
          if (wr_ptr_q == LAST_PTR) begin
            state_d = ST_READOUT;
          end
        end
      end

      ST_READOUT: begin
        accept   = rd_valid_q && rd_ready;
        // The prefetched RAM word moves to the output whenever the output slot is free or draining.
        load_out = pend_q && (!rd_valid_q || rd_ready);
        ram_re   = (rd_ptr_q != FULL_PTR) && (!pend_q || load_out);
        if (ram_re) begin
          rd_ptr_d = rd_ptr_q + ONE_PTR;
        end
        pend_d = ram_re || (pend_q && !load_out);

        if (load_out) begin
          rd_valid_d = 1'b1;
          rd_data1_d = ram_rdata[PAIR_W-1:DATA_WIDTH];
          rd_data2_d = ram_rdata[DATA_WIDTH-1:0];
          rd_last_d  = (rd_ptr_q == FULL_PTR);
        end else if (accept) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end

        if (accept && rd_last_q) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pend_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_data1_q   <= '0;
      rd_data2_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_q       <= pend_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_data1_q   <= rd_data1_d;
      rd_data2_q   <= rd_data2_d;
      done_q       <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;

endmodule
